// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Brief    : State, op-select encodings and width helpers for the sequential
//            radix-2 Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // One guard bit keeps -M representable for the most negative operand.
   function automatic int ext_width(input int w);
      return w + 1;
   endfunction

   function automatic booth_op_t booth_sel(input logic q0, input logic qm1);
      case ({q0, qm1})
         2'b10:   return OP_SUB;
         2'b01:   return OP_ADD;
         default: return OP_NOP;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_addsub.sv
`default_nettype none
// ============================================================================
// Module   : booth_addsub
// Brief    : Combinational add/subtract used for the Booth accumulator update.
// Revision : 1.0 - initial release
// ============================================================================
module booth_addsub
   import booth_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] result
);

   assign result = sub ? (a - b) : (a + b);

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Sequential radix-2 Booth multiplier with valid/ready handshakes.
//            Optional macro BOOTH_UNSIGNED_EN adds the tc (signed/unsigned) port.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W + 2)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
`ifdef BOOTH_UNSIGNED_EN
   input  logic           tc,
`endif
   input  logic [W-1:0]   multiplicand,
   input  logic [W-1:0]   multiplier,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] product,
   output logic           busy
);

   localparam int AW = ext_width(W);
   localparam int SW = W + 2;
`ifdef BOOTH_UNSIGNED_EN
   localparam int QW = ext_width(W);
`else
   localparam int QW = W;
`endif

   state_t           state;
   state_t           state_next;
   booth_op_t        op;
   logic [AW-1:0]    a;
   logic [AW-1:0]    m;
   logic [AW-1:0]    a_sh;
   logic [AW-1:0]    m_ext;
   logic [QW-1:0]    q;
   logic [QW-1:0]    q_sh;
   logic [QW-1:0]    q_ext;
   logic             qm1;
   logic             qm1_sh;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] last_cnt;
   logic [2*W-1:0]   prod_next;
   logic [SW-1:0]    addsub_sum;
   logic             unused_sum_msb;
   logic             last_iter;

   assign op = booth_sel(q[0], qm1);

   booth_addsub #(
      .WIDTH (SW)
   ) u_addsub (
      .a      ({a[AW-1], a}),
      .b      ({m[AW-1], m}),
      .sub    (op == OP_SUB),
      .result (addsub_sum)
   );

   assign unused_sum_msb = addsub_sum[SW-1];

   // Arithmetic right shift of {A,Q,Qm1}: A's sign bit is replicated.
   assign {a_sh, q_sh, qm1_sh} = {a[AW-1], a, q};

`ifdef BOOTH_UNSIGNED_EN
   logic uns;

   always_ff @(posedge clk) begin
      if (reset) begin
         uns <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         uns <= ~tc;
      end
   end

   assign m_ext    = {tc & multiplicand[W-1], multiplicand};
   assign q_ext    = {tc & multiplier[W-1], multiplier};
   assign last_cnt = uns ? CNT_W'(W) : CNT_W'(W - 1);
   // Signed mode runs only W steps, so the product sits one bit higher in Q.
   assign prod_next = uns ? {a_sh[W-2:0], q_sh} : {a_sh[W-1:0], q_sh[QW-1:1]};
`else
   assign m_ext     = {multiplicand[W-1], multiplicand};
   assign q_ext     = multiplier;
   assign last_cnt  = CNT_W'(W - 1);
   assign prod_next = {a_sh[W-1:0], q_sh};
`endif

   assign last_iter = (count == last_cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = ADD;
         ADD:     state_next = SHIFT;
         SHIFT:   state_next = last_iter ? DONE : ADD;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a       <= '0;
         m       <= '0;
         q       <= '0;
         qm1     <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a     <= '0;
                  m     <= m_ext;
                  q     <= q_ext;
                  qm1   <= 1'b0;
                  count <= '0;
               end
            end
            ADD: begin
               if (op != OP_NOP) a <= addsub_sum[AW-1:0];
            end
            SHIFT: begin
               a     <= a_sh;
               q     <= q_sh;
               qm1   <= qm1_sh;
               count <= count + CNT_W'(1);
               if (last_iter) product <= prod_next;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_seq
// Brief    : Randomised self-checking bench for booth_mult_seq (W=8 and W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
   logic [7:0]  mc_8, mp_8;
   logic [15:0] product_8;
   logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
   logic [15:0] mc_16, mp_16;
   logic [31:0] product_16;
`ifdef BOOTH_UNSIGNED_EN
   logic        tc_8, tc_16;
`endif
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   booth_mult_seq #(.W(8)) u_dut8 (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid_8),
      .in_ready     (in_ready_8),
`ifdef BOOTH_UNSIGNED_EN
      .tc           (tc_8),
`endif
      .multiplicand (mc_8),
      .multiplier   (mp_8),
      .out_valid    (out_valid_8),
      .out_ready    (out_ready_8),
      .product      (product_8),
      .busy         (busy_8)
   );

   booth_mult_seq #(.W(16)) u_dut16 (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid_16),
      .in_ready     (in_ready_16),
`ifdef BOOTH_UNSIGNED_EN
      .tc           (tc_16),
`endif
      .multiplicand (mc_16),
      .multiplier   (mp_16),
      .out_valid    (out_valid_16),
      .out_ready    (out_ready_16),
      .product      (product_16),
      .busy         (busy_16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Plain-arithmetic reference: extend operands, multiply, keep 2W bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic sgn);
      longint span, x, y, mask;
      span = longint'(1) << w;
      x    = longint'(a) & (span - 1);
      y    = longint'(b) & (span - 1);
      if (sgn && x >= span / 2) x -= span;
      if (sgn && y >= span / 2) y -= span;
      mask = (longint'(1) << (2 * w)) - 1;
      return 64'((x * y) & mask);
   endfunction

   function automatic logic get_rdy(input int w);
      return (w == 8) ? in_ready_8 : in_ready_16;
   endfunction

   function automatic logic get_ov(input int w);
      return (w == 8) ? out_valid_8 : out_valid_16;
   endfunction

   function automatic logic get_busy(input int w);
      return (w == 8) ? busy_8 : busy_16;
   endfunction

   function automatic logic [63:0] get_prod(input int w);
      return (w == 8) ? 64'(product_8) : 64'(product_16);
   endfunction

   task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic iv, input logic ordy);
      if (w == 8) begin
         mc_8 = a[7:0];  mp_8 = b[7:0];  in_valid_8 = iv;  out_ready_8 = ordy;
      end else begin
         mc_16 = a[15:0]; mp_16 = b[15:0]; in_valid_16 = iv; out_ready_16 = ordy;
      end
   endtask

   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic tcv, input int hold, input string tag);
      logic [63:0] exp_p;
      logic [63:0] got;
      int          n;
      int          lat;
      n     = tcv ? w : w + 1;
      exp_p = ref_mul(a, b, w, tcv);
      @(negedge clk);
`ifdef BOOTH_UNSIGNED_EN
      if (w == 8) tc_8 = tcv; else tc_16 = tcv;
`endif
      drive(w, a, b, 1'b1, hold == 0);
      check({tag, "_rdy"}, 64'(get_rdy(w)), 64'd1);
      @(posedge clk); #1;
      drive(w, a, b, 1'b0, hold == 0);
      lat = 0;
      while (!get_ov(w) && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(2 * n));
      got = get_prod(w);
      check({tag, "_prod"}, got, exp_p);
      if (hold > 0) begin
         drive(w, ~a, b, 1'b1, 1'b0);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_prod"}, get_prod(w), got);
            check({tag, "_hold_flags"}, 64'({get_ov(w), get_rdy(w), get_busy(w)}), 64'(3'b101));
         end
         drive(w, a, b, 1'b0, 1'b1);
      end
      @(posedge clk); #1;
      check({tag, "_ret"}, 64'({get_ov(w), get_rdy(w), get_busy(w)}), 64'(3'b010));
      check({tag, "_keep"}, get_prod(w), got);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rt;
      reset = 1'b1;
      drive(8, 0, 0, 1'b0, 1'b0);
      drive(16, 0, 0, 1'b0, 1'b0);
`ifdef BOOTH_UNSIGNED_EN
      tc_8  = 1'b1;
      tc_16 = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst8_flags", 64'({out_valid_8, in_ready_8, busy_8}), 64'(3'b010));
      check("rst8_prod", 64'(product_8), 64'd0);
      check("rst16_flags", 64'({out_valid_16, in_ready_16, busy_16}), 64'(3'b010));
      check("rst16_prod", 64'(product_16), 64'd0);
      reset = 1'b0;

      run_op(8, 32'd3, 32'd5, 1'b1, 0, "d_3x5");
      run_op(8, 32'h80, 32'h80, 1'b1, 0, "d_m128sq");
      run_op(8, 32'hF9, 32'd6, 1'b1, 10, "d_m7x6");

      // Reset lands in the 5th SHIFT cycle of 100 x 100.
      @(negedge clk);
`ifdef BOOTH_UNSIGNED_EN
      tc_8 = 1'b1;
`endif
      drive(8, 32'd100, 32'd100, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(8, 32'd100, 32'd100, 1'b0, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      check("midrst_busy", 64'(busy_8), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_flags", 64'({out_valid_8, in_ready_8, busy_8}), 64'(3'b010));
      check("midrst_prod", 64'(product_8), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("midrst_noval", 64'(out_valid_8), 64'd0);
      run_op(8, 32'd2, 32'd2, 1'b1, 0, "d_2x2");

      run_op(8, 32'd0, 32'd77, 1'b1, 0, "d_0xb");
      run_op(8, 32'd55, 32'd0, 1'b1, 0, "d_ax0");
`ifdef BOOTH_UNSIGNED_EN
      run_op(8, 32'hFF, 32'hFF, 1'b0, 0, "u_ffxff");
      run_op(8, 32'hFF, 32'hFF, 1'b1, 0, "s_ffxff");
`endif
      run_op(16, 32'h8000, 32'h7FFF, 1'b1, 0, "d16_minxmax");

      for (int k = 0; k < 1000; k++) begin
         ra = $urandom & 32'hFF;
         rb = $urandom & 32'hFF;
`ifdef BOOTH_UNSIGNED_EN
         rt = 1'($urandom_range(0, 1));
`else
         rt = 1'b1;
`endif
         run_op(8, ra, rb, rt, (k % 50 == 7) ? 2 : 0, "r8");
      end
      for (int k = 0; k < 200; k++) begin
         ra = $urandom & 32'hFFFF;
         rb = $urandom & 32'hFFFF;
`ifdef BOOTH_UNSIGNED_EN
         rt = 1'($urandom_range(0, 1));
`else
         rt = 1'b1;
`endif
         run_op(16, ra, rb, rt, 0, "r16");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
